// File: rtl/cache_assoc_ctrl.sv
// 2-way set-associative cache controller with true-LRU replacement.
// Write-through, no-write-allocate; read misses fill a whole block, one word per beat.
//
// state | meaning
// IDLE  | serve read hits combinationally, accept a write or a read miss
// FILL  | request every word of the block, store each returned beat into the victim way
// WRITE | forward the latched write to memory and hold it until acknowledged
module cache_assoc_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  parameter int N_SETS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_MemRead,
  input  logic [ADDR_W-1:0] pipe_read_addr,
  input  logic              pipe_MemWrite,
  input  logic [ADDR_W-1:0] pipe_mem_write_addr,
  input  logic [DATA_W-1:0] pipe_mem_write_data,
  input  logic              MemDataValid,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              cache_MemRead,
  output logic              cache_MemWrite,
  output logic [ADDR_W-1:0] cache_mem_addr,
  output logic [DATA_W-1:0] cache_mem_data_out,
  output logic [DATA_W-1:0] cache_data_out,
  output logic              CacheHit,
  output logic              CacheBusy,
  output logic              CacheFinish
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(N_SETS);
  localparam int TAG_LO = OFF_W + IDX_W + 1;
  localparam int TAG_W  = ADDR_W - TAG_LO;
  localparam int CNT_W  = OFF_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state, state_nxt;

  logic [1:0]        valid    [N_SETS];
  logic [N_SETS-1:0] lru;
  logic [TAG_W-1:0]  tag_mem  [N_SETS][2];
  logic [DATA_W-1:0] data_mem [N_SETS][2][WORDS];

  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              victim;
  logic [CNT_W-1:0]  req_cnt;
  logic [OFF_W-1:0]  rcv_cnt;

  // read-port decode and lookup
  logic [OFF_W-1:0] rd_off;
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit0, rd_hit1, rd_way, victim_sel;

  assign rd_off  = pipe_read_addr[OFF_W:1];
  assign rd_idx  = pipe_read_addr[TAG_LO-1:OFF_W+1];
  assign rd_tag  = pipe_read_addr[ADDR_W-1:TAG_LO];
  assign rd_hit0 = valid[rd_idx][0] && (tag_mem[rd_idx][0] == rd_tag);
  assign rd_hit1 = valid[rd_idx][1] && (tag_mem[rd_idx][1] == rd_tag);
  assign rd_way  = !rd_hit0;
  // an invalid way is always preferred over evicting live data
  assign victim_sel = !valid[rd_idx][0] ? 1'b0 :
                      !valid[rd_idx][1] ? 1'b1 : lru[rd_idx];

  // latched-address decode, shared by FILL and WRITE
  logic [OFF_W-1:0] l_off;
  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit0, l_hit1, l_way;

  assign l_off  = lat_addr[OFF_W:1];
  assign l_idx  = lat_addr[TAG_LO-1:OFF_W+1];
  assign l_tag  = lat_addr[ADDR_W-1:TAG_LO];
  assign l_hit0 = valid[l_idx][0] && (tag_mem[l_idx][0] == l_tag);
  assign l_hit1 = valid[l_idx][1] && (tag_mem[l_idx][1] == l_tag);
  assign l_way  = !l_hit0;

  logic fill_beat, fill_last, wr_upd;
  assign fill_beat = (state == FILL) && MemDataValid;
  assign fill_last = fill_beat && (&rcv_cnt);
  assign wr_upd    = (state == WRITE) && MemDataValid && (l_hit0 || l_hit1);

  // byte address bit 0 carries no word information
  logic unused_addr_lsb;
  assign unused_addr_lsb = pipe_read_addr[0] ^ pipe_mem_write_addr[0];

  logic start_fill, start_wr, rd_hit_upd;

  // next state and outputs; everything is held at 0 while reset is asserted
  always_comb begin
    state_nxt          = state;
    cache_MemRead      = 1'b0;
    cache_MemWrite     = 1'b0;
    cache_mem_addr     = '0;
    cache_mem_data_out = '0;
    cache_data_out     = '0;
    CacheHit           = 1'b0;
    CacheBusy          = 1'b0;
    CacheFinish        = 1'b0;
    start_fill         = 1'b0;
    start_wr           = 1'b0;
    rd_hit_upd         = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (pipe_MemWrite) begin
            start_wr  = 1'b1;
            CacheBusy = 1'b1;
            state_nxt = WRITE;
          end else if (pipe_MemRead) begin
            if (rd_hit0 || rd_hit1) begin
              CacheHit       = 1'b1;
              cache_data_out = data_mem[rd_idx][rd_way][rd_off];
              rd_hit_upd     = 1'b1;
            end else begin
              CacheBusy  = 1'b1;
              start_fill = 1'b1;
              state_nxt  = FILL;
            end
          end
        end
        FILL: begin
          CacheBusy = 1'b1;
          if (!req_cnt[OFF_W]) begin
            cache_MemRead  = 1'b1;
            cache_mem_addr = {lat_addr[ADDR_W-1:OFF_W+1], req_cnt[OFF_W-1:0], 1'b0};
          end
          if (fill_last) begin
            CacheFinish = 1'b1;
            state_nxt   = IDLE;
          end
        end
        WRITE: begin
          CacheBusy          = 1'b1;
          cache_MemWrite     = 1'b1;
          cache_mem_addr     = lat_addr;
          cache_mem_data_out = lat_data;
          if (MemDataValid) begin
            CacheFinish = 1'b1;
            state_nxt   = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // state, valid/lru bookkeeping, request latches and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lru      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      victim   <= 1'b0;
      req_cnt  <= '0;
      rcv_cnt  <= '0;
      for (int s = 0; s < N_SETS; s++) valid[s] <= 2'b00;
    end else begin
      state <= state_nxt;
      if (start_wr) begin
        lat_addr <= pipe_mem_write_addr;
        lat_data <= pipe_mem_write_data;
      end
      if (start_fill) begin
        lat_addr <= pipe_read_addr;
        victim   <= victim_sel;
        req_cnt  <= '0;
        rcv_cnt  <= '0;
        // the victim is overwritten word by word, so it stops being valid now
        valid[rd_idx][victim_sel] <= 1'b0;
      end
      if (rd_hit_upd) lru[rd_idx] <= !rd_way;
      if (state == FILL && !req_cnt[OFF_W]) req_cnt <= req_cnt + 1'b1;
      if (fill_beat) rcv_cnt <= rcv_cnt + 1'b1;
      if (fill_last) begin
        valid[l_idx][victim] <= 1'b1;
        lru[l_idx]           <= !victim;
      end
      if (wr_upd) lru[l_idx] <= !l_way;
    end
  end

  // tag and data arrays carry no reset; valid bits qualify them
  always_ff @(posedge clk) begin
    if (fill_beat) data_mem[l_idx][victim][rcv_cnt] <= mem_read_data;
    if (fill_last) tag_mem[l_idx][victim] <= l_tag;
    if (wr_upd) data_mem[l_idx][l_way][l_off] <= lat_data;
  end

endmodule

// File: tb/tb_cache_assoc_ctrl.sv
// Directed bench for cache_assoc_ctrl with default parameters.
module tb_cache_assoc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_MemRead;
  logic [15:0] pipe_read_addr;
  logic        pipe_MemWrite;
  logic [15:0] pipe_mem_write_addr;
  logic [15:0] pipe_mem_write_data;
  logic        MemDataValid;
  logic [15:0] mem_read_data;
  logic        cache_MemRead;
  logic        cache_MemWrite;
  logic [15:0] cache_mem_addr;
  logic [15:0] cache_mem_data_out;
  logic [15:0] cache_data_out;
  logic        CacheHit;
  logic        CacheBusy;
  logic        CacheFinish;

  int tests = 0;
  int fails = 0;

  cache_assoc_ctrl dut (
    .clk(clk), .rst(rst),
    .pipe_MemRead(pipe_MemRead), .pipe_read_addr(pipe_read_addr),
    .pipe_MemWrite(pipe_MemWrite), .pipe_mem_write_addr(pipe_mem_write_addr),
    .pipe_mem_write_data(pipe_mem_write_data),
    .MemDataValid(MemDataValid), .mem_read_data(mem_read_data),
    .cache_MemRead(cache_MemRead), .cache_MemWrite(cache_MemWrite),
    .cache_mem_addr(cache_mem_addr), .cache_mem_data_out(cache_mem_data_out),
    .cache_data_out(cache_data_out), .CacheHit(CacheHit),
    .CacheBusy(CacheBusy), .CacheFinish(CacheFinish)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; pipe_MemRead = 1'b0; pipe_read_addr = '0; pipe_MemWrite = 1'b0;
    pipe_mem_write_addr = '0; pipe_mem_write_data = '0; MemDataValid = 1'b0; mem_read_data = '0;
    #12;
    tests++;
    if ({cache_MemRead, cache_MemWrite, cache_mem_addr, cache_mem_data_out, cache_data_out,
         CacheHit, CacheBusy, CacheFinish} !== '0) begin
      fails++; $display("FAIL reset_outputs: got busy=%0b hit=%0b rd=%0b wr=%0b exp all 0",
                        CacheBusy, CacheHit, cache_MemRead, cache_MemWrite);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (CacheBusy !== 1'b0 || CacheFinish !== 1'b0) begin
      fails++; $display("FAIL idle_after_reset: got busy=%0b fin=%0b exp 0 0", CacheBusy, CacheFinish);
    end
  endtask

  // Issue a read miss at a, answer with beats d0.. starting lag cycles into FILL.
  task automatic do_fill(input logic [15:0] a, input logic [15:0] d0, input int lag, input string nm);
    logic [15:0] base, exp_a;
    int beats, c;
    base = a & 16'hFFF0;
    @(negedge clk); pipe_MemRead = 1'b1; pipe_read_addr = a; #1;
    tests++;
    if (CacheBusy !== 1'b1 || CacheHit !== 1'b0 || cache_data_out !== 16'h0) begin
      fails++; $display("FAIL %s miss: got busy=%0b hit=%0b data=%h exp 1 0 0000", nm, CacheBusy, CacheHit, cache_data_out);
    end
    beats = 0; c = 0;
    while (beats < 8 && c < 40) begin
      @(negedge clk);
      exp_a = base + 16'(2 * c);
      tests++;
      if (c < 8) begin
        if (cache_MemRead !== 1'b1 || cache_mem_addr !== exp_a || CacheBusy !== 1'b1) begin
          fails++; $display("FAIL %s req%0d: got rd=%0b addr=%h busy=%0b exp 1 %h 1", nm, c, cache_MemRead, cache_mem_addr, CacheBusy, exp_a);
        end
      end else if (cache_MemRead !== 1'b0 || CacheBusy !== 1'b1) begin
        fails++; $display("FAIL %s req_done%0d: got rd=%0b busy=%0b exp 0 1", nm, c, cache_MemRead, CacheBusy);
      end
      if (c >= lag) begin
        MemDataValid = 1'b1; mem_read_data = d0 + 16'(beats); #1;
        tests++;
        if (CacheFinish !== (beats == 7)) begin
          fails++; $display("FAIL %s finish_beat%0d: got %0b exp %0b", nm, beats, CacheFinish, beats == 7);
        end
        beats++;
      end else begin
        MemDataValid = 1'b0;
      end
      c++;
    end
    tests++;
    if (beats != 8) begin
      fails++; $display("FAIL %s timeout: got %0d beats exp 8", nm, beats);
    end
    @(negedge clk); MemDataValid = 1'b0; #1;
    tests++;
    if (CacheHit !== 1'b1 || cache_data_out !== d0 + 16'(a[3:1]) || CacheBusy !== 1'b0 ||
        cache_MemRead !== 1'b0 || CacheFinish !== 1'b0) begin
      fails++; $display("FAIL %s rehit: got hit=%0b data=%h busy=%0b rd=%0b fin=%0b exp 1 %h 0 0 0",
                        nm, CacheHit, cache_data_out, CacheBusy, cache_MemRead, CacheFinish, d0 + 16'(a[3:1]));
    end
    pipe_MemRead = 1'b0;
  endtask

  task automatic read_hit(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); pipe_MemRead = 1'b1; pipe_read_addr = a; #1;
    tests++;
    if (CacheHit !== 1'b1 || cache_data_out !== d || CacheBusy !== 1'b0 || cache_MemRead !== 1'b0) begin
      fails++; $display("FAIL read_hit %h: got hit=%0b data=%h busy=%0b rd=%0b exp 1 %h 0 0",
                        a, CacheHit, cache_data_out, CacheBusy, cache_MemRead, d);
    end
    @(posedge clk); #1 pipe_MemRead = 1'b0;
  endtask

  task automatic check_miss(input logic [15:0] a);
    @(negedge clk); pipe_MemRead = 1'b1; pipe_read_addr = a; #1;
    tests++;
    if (CacheHit !== 1'b0 || CacheBusy !== 1'b1 || cache_data_out !== 16'h0) begin
      fails++; $display("FAIL miss %h: got hit=%0b busy=%0b data=%h exp 0 1 0000", a, CacheHit, CacheBusy, cache_data_out);
    end
    pipe_MemRead = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int lag);
    @(negedge clk); pipe_MemWrite = 1'b1; pipe_mem_write_addr = a; pipe_mem_write_data = d;
    @(negedge clk); pipe_MemWrite = 1'b0; pipe_mem_write_data = ~d;
    for (int c = 0; c <= lag; c++) begin
      #1;
      tests++;
      if (cache_MemWrite !== 1'b1 || cache_mem_addr !== a || cache_mem_data_out !== d ||
          CacheBusy !== 1'b1 || CacheFinish !== 1'b0) begin
        fails++; $display("FAIL write %h hold%0d: got wr=%0b addr=%h data=%h busy=%0b fin=%0b exp 1 %h %h 1 0",
                          a, c, cache_MemWrite, cache_mem_addr, cache_mem_data_out, CacheBusy, CacheFinish, a, d);
      end
      if (c < lag) @(negedge clk);
    end
    MemDataValid = 1'b1; #1;
    tests++;
    if (CacheFinish !== 1'b1) begin
      fails++; $display("FAIL write %h ack_finish: got %0b exp 1", a, CacheFinish);
    end
    @(negedge clk); MemDataValid = 1'b0; #1;
    tests++;
    if (cache_MemWrite !== 1'b0 || CacheFinish !== 1'b0 || CacheBusy !== 1'b0) begin
      fails++; $display("FAIL write %h done: got wr=%0b fin=%0b busy=%0b exp 0 0 0", a, cache_MemWrite, CacheFinish, CacheBusy);
    end
  endtask

  task automatic test_cold_fill();
    do_fill(16'h0000, 16'h0001, 0, "cold_fill");
  endtask

  task automatic test_read_sweep();
    for (int i = 0; i < 8; i++) read_hit(16'(2 * i), 16'(i + 1));
    do_fill(16'h0010, 16'h0100, 2, "fill_0010");
    for (int i = 0; i < 8; i++) read_hit(16'h0010 + 16'(2 * i), 16'h0100 + 16'(i));
  endtask

  task automatic test_top_block();
    do_fill(16'hFFFE, 16'hF000, 0, "fill_fffe");
    read_hit(16'hFFF0, 16'hF000);
  endtask

  task automatic test_conflict();
    do_fill(16'h0100, 16'h1100, 1, "fill_0100");
    read_hit(16'h0000, 16'h0001);
    do_fill(16'h0200, 16'h2200, 0, "fill_0200");
    read_hit(16'h0000, 16'h0001);
    read_hit(16'h0206, 16'h2203);
    check_miss(16'h0100);
  endtask

  task automatic test_write();
    do_write(16'h0004, 16'hBEEF, 2);
    read_hit(16'h0004, 16'hBEEF);
    read_hit(16'h0002, 16'h0002);
    read_hit(16'h0006, 16'h0004);
    do_write(16'h0400, 16'h4444, 0);
    check_miss(16'h0400);
    read_hit(16'h0000, 16'h0001);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    pipe_MemRead = 1'b1; pipe_read_addr = 16'h0000;
    pipe_MemWrite = 1'b1; pipe_mem_write_addr = 16'h0008; pipe_mem_write_data = 16'h1234; #1;
    tests++;
    if (CacheHit !== 1'b0 || cache_data_out !== 16'h0) begin
      fails++; $display("FAIL b2b write_first: got hit=%0b data=%h exp 0 0000", CacheHit, cache_data_out);
    end
    @(negedge clk); pipe_MemWrite = 1'b0; #1;
    tests++;
    if (cache_MemWrite !== 1'b1 || cache_mem_addr !== 16'h0008 || CacheHit !== 1'b0) begin
      fails++; $display("FAIL b2b write_state: got wr=%0b addr=%h hit=%0b exp 1 0008 0", cache_MemWrite, cache_mem_addr, CacheHit);
    end
    MemDataValid = 1'b1; #1;
    tests++;
    if (CacheFinish !== 1'b1) begin
      fails++; $display("FAIL b2b finish: got %0b exp 1", CacheFinish);
    end
    @(negedge clk); MemDataValid = 1'b0; #1;
    tests++;
    if (CacheHit !== 1'b1 || cache_data_out !== 16'h0001 || CacheBusy !== 1'b0) begin
      fails++; $display("FAIL b2b read_after: got hit=%0b data=%h busy=%0b exp 1 0001 0", CacheHit, cache_data_out, CacheBusy);
    end
    pipe_MemRead = 1'b0;
    read_hit(16'h0008, 16'h1234);
  endtask

  task automatic test_idle_valid();
    @(negedge clk); MemDataValid = 1'b1; mem_read_data = 16'hDEAD; #1;
    tests++;
    if (CacheFinish !== 1'b0 || CacheBusy !== 1'b0) begin
      fails++; $display("FAIL idle_valid: got fin=%0b busy=%0b exp 0 0", CacheFinish, CacheBusy);
    end
    @(negedge clk); MemDataValid = 1'b0;
    read_hit(16'h000E, 16'h0008);
  endtask

  task automatic test_reset_mid_fill();
    @(negedge clk); pipe_MemRead = 1'b1; pipe_read_addr = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); MemDataValid = 1'b1; mem_read_data = 16'h0055 + 16'(i);
    end
    @(negedge clk); MemDataValid = 1'b0; #1;
    tests++;
    if (cache_MemRead !== 1'b1 || CacheBusy !== 1'b1) begin
      fails++; $display("FAIL mid_fill: got rd=%0b busy=%0b exp 1 1", cache_MemRead, CacheBusy);
    end
    rst = 1'b1; #1;
    tests++;
    if ({cache_MemRead, cache_MemWrite, cache_mem_addr, cache_mem_data_out, cache_data_out,
         CacheHit, CacheBusy, CacheFinish} !== '0) begin
      fails++; $display("FAIL reset_mid_fill: got busy=%0b rd=%0b addr=%h exp all 0", CacheBusy, cache_MemRead, cache_mem_addr);
    end
    @(negedge clk); rst = 1'b0; pipe_MemRead = 1'b0;
    check_miss(16'h0000);
    do_fill(16'h0030, 16'h0700, 1, "refill_0030");
    for (int i = 0; i < 8; i++) read_hit(16'h0030 + 16'(2 * i), 16'h0700 + 16'(i));
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_read_sweep();
    test_top_block();
    test_conflict();
    test_write();
    test_back_to_back();
    test_idle_valid();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_assoc_ctrl.md
Name: cache_assoc_ctrl

Overview:
- Parametrised successor to the team's direct-mapped CACHE block: an N_SETS x 2-way set-associative cache with true-LRU replacement, parametrised block size, and a write-through, no-write-allocate policy.
- Sits between a pipeline stage and the multi-cycle memory model, as I-cache (writes tied 0) or D-cache.
- Read misses fill a whole block, one word per MemDataValid beat.
- Writes are forwarded to memory and held until memory acknowledges.

Parameters:
- ADDR_W, 16: byte address width.
- DATA_W, 16: word width. Words are 2-byte aligned; addr[0] is ignored.
- WORDS, 8: words per block; power of 2, at least 2.
- N_SETS, 16: number of sets; power of 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pipe_MemRead  in  1  pipeline read request.
- pipe_read_addr  in  ADDR_W  read byte address.
- pipe_MemWrite  in  1  pipeline write request.
- pipe_mem_write_addr  in  ADDR_W  write byte address.
- pipe_mem_write_data  in  DATA_W  write data.
- MemDataValid  in  1  memory read-data valid (FILL) or write acknowledge (WRITE).
- mem_read_data  in  DATA_W  memory read data.
- cache_MemRead  out  1  cache read request to memory.
- cache_MemWrite  out  1  cache write request to memory.
- cache_mem_addr  out  ADDR_W  memory address.
- cache_mem_data_out  out  DATA_W  memory write data.
- cache_data_out  out  DATA_W  read data to pipeline.
- CacheHit  out  1  current read request hits.
- CacheBusy  out  1  stall the pipeline.
- CacheFinish  out  1  one-cycle pulse when a fill or write completes.

Behaviour:
- Address split: offset = addr[log2(WORDS):1]; index = next log2(N_SETS) bits; tag = the remaining upper bits.
- Per-set storage: valid[2], tag[2], data[2][WORDS], lru (1 bit, names the way to replace next).
- Reset, asynchronous: all valid and lru bits cleared; FSM to IDLE; counters to 0; every output 0. Data array is not reset. Reset during FILL or WRITE aborts the operation; no partial line is ever marked valid.
- FSM states: IDLE, FILL, WRITE.
- IDLE priority: write is served before read.
  - pipe_MemWrite=1: latch address and data; go to WRITE.
  - Else pipe_MemRead=1 and hit: same-cycle combinational CacheHit=1, cache_data_out = hit word, CacheBusy=0. On the clock edge, lru <= other way.
  - Else pipe_MemRead=1 and miss: CacheBusy=1 combinationally. Latch address; choose victim (first invalid way, way0 before way1, else the lru way); go to FILL.
  - Idle outputs: cache_data_out=0 when not hitting; CacheHit=0 when pipe_MemRead=0.
- FILL state:
  - CacheBusy=1.
  - Request counter req_cnt runs 0..WORDS-1. cache_MemRead=1 and cache_mem_addr = block_base + 2*req_cnt while req_cnt<WORDS; req_cnt advances every cycle.
  - Receive counter rcv_cnt: on each MemDataValid=1 cycle, mem_read_data is written to victim word rcv_cnt and rcv_cnt increments.
  - On the beat where rcv_cnt=WORDS-1: set valid and tag, lru <= other way, CacheFinish=1 for that cycle, return to IDLE.
  - The request is then re-evaluated as a hit on the next cycle. Pipeline inputs are ignored during FILL.
- WRITE state:
  - cache_MemWrite=1, cache_mem_addr and cache_mem_data_out = latched values, CacheBusy=1.
  - On MemDataValid=1: if the address hits in either way, update that word and lru; no allocation on a miss. CacheFinish=1 that cycle; return to IDLE.
- Counter wrap: block_base has offset bits zero; counters wrap at WORDS. Address 0xFFFE fills the top block with no carry past ADDR_W.
- MemDataValid in IDLE is ignored.

Test Plan:
- Cold read of 0x0000 -> CacheBusy=1. cache_MemRead addresses 0,2,...,14 on consecutive cycles. After 8 MemDataValid beats with data 1..8: CacheFinish one pulse; the next cycle gives CacheHit=1, cache_data_out=1.
- After the fill, reads of 0x0000..0x000E, one per cycle -> CacheHit=1 every cycle, data 1..8, cache_MemRead=0. A read of 0x0010 -> miss and fill.
- Conflict (defaults): fill 0x0000 (way0), fill 0x0100 (way1), read 0x0000, fill 0x0200 -> way1 is evicted. 0x0000 still hits; 0x0100 misses.
- Write 0x0004 := 0xBEEF after the fill -> cache_MemWrite held until ack, CacheFinish pulse. A later read of 0x0004 hits with 0xBEEF. A write to uncached 0x0400 -> read of 0x0400 misses.
- Same-cycle read and write -> write served first, then the read.
- rst after 3 fill beats -> all outputs 0 immediately. A read of the same address after reset misses and refills all 8 words.
